// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC register, single-outstanding imem sequencing,
// one-entry fetch buffer and the IF/ID pipeline register.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic [1:0]  PcSrc,
  input  logic [31:0] PcTargetE,
  input  logic [31:0] AluResultE,
  output logic        ImemReqValid,
  input  logic        ImemReqReady,
  output logic [31:0] ImemAddr,
  input  logic        ImemRspValid,
  input  logic [31:0] ImemRspData,
  output logic [31:0] InstrD,
  output logic [31:0] PcD,
  output logic [31:0] PcPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc_f;
  logic [31:0] req_pc;
  logic        buf_valid;
  logic [31:0] buf_instr;
  logic [31:0] buf_pc;

  logic        redirect;
  logic [31:0] target;
  logic        rsp_wait;
  logic        rsp_accept;
  logic        space;
  logic        handshake;

  // Issue is allowed only when the buffer is guaranteed empty at end of cycle.
  always_comb begin
    redirect = (PcSrc != 2'b00);
    target   = (PcSrc == 2'b10) ? (AluResultE & 32'hFFFF_FFFE) : PcTargetE;
    rsp_wait = ImemRspValid && (state == S_WAIT);
    if (FlushD) begin
      space = 1'b1;
    end else if (buf_valid) begin
      space = !StallD;
    end else begin
      space = !(rsp_wait && StallD);
    end
    ImemReqValid = !reset && !StallF && ((state == S_IDLE) || ImemRspValid) && space;
    handshake    = ImemReqValid && ImemReqReady;
    rsp_accept   = rsp_wait && !redirect;
  end

  assign ImemAddr = pc_f;

  // PC register and tracker of the single outstanding request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      pc_f   <= RESET_PC;
      req_pc <= 32'h0000_0000;
    end else begin
      if (redirect) begin
        pc_f <= target;
      end else if (handshake) begin
        pc_f <= pc_f + 32'd4;
      end
      if (handshake) begin
        req_pc <= pc_f;
      end
      case (state)
        S_IDLE: begin
          if (handshake) begin
            state <= redirect ? S_DROP : S_WAIT;
          end
        end
        S_WAIT: begin
          // Without a response the old request is still in flight and is now wrong-path.
          if (redirect) begin
            state <= (!ImemRspValid || handshake) ? S_DROP : S_IDLE;
          end else if (ImemRspValid) begin
            state <= handshake ? S_WAIT : S_IDLE;
          end
        end
        S_DROP: begin
          if (ImemRspValid) begin
            if (handshake) begin
              state <= redirect ? S_DROP : S_WAIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Fetch buffer and IF/ID register; flush/redirect dominates everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_instr <= 32'h0000_0000;
      buf_pc    <= 32'h0000_0000;
      InstrD    <= NOP_INSTR;
      PcD       <= 32'h0000_0000;
      PcPlus4D  <= 32'h0000_0000;
      ValidD    <= 1'b0;
    end else begin
      if (FlushD || redirect) begin
        buf_valid <= 1'b0;
        InstrD    <= NOP_INSTR;
        PcD       <= 32'h0000_0000;
        PcPlus4D  <= 32'h0000_0000;
        ValidD    <= 1'b0;
      end else if (StallD) begin
        if (rsp_accept) begin
          buf_valid <= 1'b1;
          buf_instr <= ImemRspData;
          buf_pc    <= req_pc;
        end
      end else if (buf_valid) begin
        InstrD    <= buf_instr;
        PcD       <= buf_pc;
        PcPlus4D  <= buf_pc + 32'd4;
        ValidD    <= 1'b1;
        buf_valid <= rsp_accept;
        if (rsp_accept) begin
          buf_instr <= ImemRspData;
          buf_pc    <= req_pc;
        end
      end else if (rsp_accept) begin
        InstrD   <= ImemRspData;
        PcD      <= req_pc;
        PcPlus4D <= req_pc + 32'd4;
        ValidD   <= 1'b1;
      end else begin
        InstrD   <= NOP_INSTR;
        PcD      <= 32'h0000_0000;
        PcPlus4D <= 32'h0000_0000;
        ValidD   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized bench for fetch_stage with a variable-latency memory
// model and a program-order scoreboard of the instruction stream.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk          = 1'b0;
  logic        reset        = 1'b0;
  logic        StallF       = 1'b0;
  logic        StallD       = 1'b0;
  logic        FlushD       = 1'b0;
  logic [1:0]  PcSrc        = 2'b00;
  logic [31:0] PcTargetE    = 32'h0;
  logic [31:0] AluResultE   = 32'h0;
  logic        ImemReqReady = 1'b0;
  logic        ImemRspValid = 1'b0;
  logic [31:0] ImemRspData  = 32'h0;
  logic        ImemReqValid;
  logic [31:0] ImemAddr;
  logic [31:0] InstrD;
  logic [31:0] PcD;
  logic [31:0] PcPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .PcSrc(PcSrc), .PcTargetE(PcTargetE), .AluResultE(AluResultE),
    .ImemReqValid(ImemReqValid), .ImemReqReady(ImemReqReady), .ImemAddr(ImemAddr),
    .ImemRspValid(ImemRspValid), .ImemRspData(ImemRspData),
    .InstrD(InstrD), .PcD(PcD), .PcPlus4D(PcPlus4D), .ValidD(ValidD)
  );

  int n_checks = 0;
  int n_errors = 0;

  // memory model: at most one pending request, countdown to its response
  logic        mem_busy = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  int          mem_cnt  = 0;

  // reference model: fetch PC, next program-order PC for decode, IF/ID contents
  typedef enum {K_BUBBLE, K_HOLD, K_FREE} kind_t;
  kind_t       kind      = K_BUBBLE;
  logic [31:0] fetch_pc  = RESET_PC;
  logic [31:0] exp_d_pc  = RESET_PC;
  logic        m_valid   = 1'b0;
  logic [31:0] m_pc      = 32'h0;
  int          deliveries = 0;
  logic        last_req  = 1'b0;
  logic [31:0] last_addr = 32'h0;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return a >> 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_instr"}, InstrD, NOP);
    chk({tag, "_pcd"}, PcD, 32'h0);
    chk({tag, "_pcp4"}, PcPlus4D, 32'h0);
    chk({tag, "_validd"}, 32'(ValidD), 32'h0);
    chk({tag, "_reqvalid"}, 32'(ImemReqValid), 32'h0);
    chk({tag, "_addr"}, ImemAddr, RESET_PC);
  endtask

  // compare IF/ID against the model for the edge that just happened
  task automatic check_if_id();
    if (kind == K_BUBBLE) begin
      m_valid = 1'b0;
    end else if (kind == K_FREE) begin
      if (ValidD === 1'b1) begin
        chk("pc_order", PcD, exp_d_pc);
        m_valid  = 1'b1;
        m_pc     = exp_d_pc;
        exp_d_pc = exp_d_pc + 32'd4;
        deliveries++;
      end else begin
        m_valid = 1'b0;
      end
    end
    if (kind != K_FREE) chk("valid_d", 32'(ValidD), 32'(m_valid));
    chk("pc_d", PcD, m_valid ? m_pc : 32'h0);
    chk("pc_plus4_d", PcPlus4D, m_valid ? (m_pc + 32'd4) : 32'h0);
    chk("instr_d", InstrD, m_valid ? word_at(m_pc) : NOP);
  endtask

  // one clock cycle; entered and left just after a falling edge
  task automatic run_cycle(input logic sf, input logic sd, input logic [1:0] src,
                           input logic [31:0] tgt, input logic [31:0] alu,
                           input logic rdy, input int lat);
    logic        hs;
    logic [31:0] t;
    check_if_id();
    StallF       = sf;
    StallD       = sd;
    PcSrc        = src;
    FlushD       = (src != 2'b00);
    PcTargetE    = tgt;
    AluResultE   = alu;
    ImemReqReady = rdy;
    ImemRspValid = mem_busy && (mem_cnt == 0);
    ImemRspData  = ImemRspValid ? word_at(mem_addr) : 32'hDEAD_BEEF;
    #1;
    last_req  = ImemReqValid;
    last_addr = ImemAddr;
    chk("imem_addr", ImemAddr, fetch_pc);
    if (sf) chk("no_req_when_stallf", 32'(ImemReqValid), 32'h0);
    hs = ImemReqValid && rdy;
    if (ImemRspValid) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (hs) begin
      chk("single_outstanding", 32'(mem_busy), 32'h0);
      mem_busy = 1'b1;
      mem_addr = ImemAddr;
      mem_cnt  = lat - 1;
    end
    t = (src == 2'b10) ? (alu & 32'hFFFF_FFFE) : tgt;
    if (src != 2'b00) begin
      fetch_pc = t;
      exp_d_pc = t;
      kind     = K_BUBBLE;
    end else begin
      if (hs) fetch_pc = fetch_pc + 32'd4;
      kind = sd ? K_HOLD : K_FREE;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    StallF       = 1'b0;
    StallD       = 1'b0;
    FlushD       = 1'b0;
    PcSrc        = 2'b00;
    ImemReqReady = 1'b1;
    ImemRspValid = 1'b0;
    ImemRspData  = 32'h0;
    mem_busy     = 1'b0;
    mem_cnt      = 0;
    #1;
    check_reset_vals("reset_async");
    repeat (2) begin
      @(negedge clk);
      check_reset_vals("reset_hold");
    end
    reset    = 1'b0;
    fetch_pc = RESET_PC;
    exp_d_pc = RESET_PC;
    m_valid  = 1'b0;
    m_pc     = 32'h0;
    kind     = K_BUBBLE;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [1:0] src;
    logic [31:0] tgt;
    int found;

    #2;
    do_reset();

    // ready=1, latency 1: back-to-back fetch, first instruction after edge 1
    for (int k = 0; k < 10; k++) begin
      run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
      chk("seq_req_every_cycle", 32'(last_req), 32'h1);
      chk("seq_addr", last_addr, 32'(4 * k));
      chk("seq_valid_latency", 32'(ValidD), (k >= 1) ? 32'h1 : 32'h0);
      if (k >= 1) chk("seq_instr", InstrD, 32'(k - 1));
    end

    // stall window with the response landing inside it
    do_reset();
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 2);
    for (int k = 0; k < 3; k++) begin
      run_cycle(1'b1, 1'b1, 2'b00, 32'h0, 32'h0, 1'b1, 1);
      chk("stall_no_req", 32'(last_req), 32'h0);
      chk("stall_hold_pc", PcD, 32'h0);
      chk("stall_hold_valid", 32'(ValidD), 32'h1);
    end
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("stall_release_req", 32'(last_req), 32'h1);
    chk("stall_release_pc", PcD, 32'h4);
    chk("stall_release_instr", InstrD, 32'h1);
    repeat (3) run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);

    // redirect to 0x100 while the request for 0x10 is outstanding
    do_reset();
    for (int k = 0; k < 5; k++) begin
      run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, (k == 4) ? 3 : 1);
    end
    chk("redir_req_addr", last_addr, 32'h10);
    run_cycle(1'b0, 1'b0, 2'b01, 32'h100, 32'h0, 1'b1, 1);
    found = 0;
    for (int k = 0; k < 10 && found == 0; k++) begin
      run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
      if (ValidD === 1'b1) found = 1;
    end
    chk("redir_delivered", 32'(found), 32'h1);
    chk("redir_pcd", PcD, 32'h100);
    chk("redir_pcp4", PcPlus4D, 32'h104);

    // jalr redirect in steady state: low bit cleared, two bubbles
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    run_cycle(1'b0, 1'b0, 2'b10, 32'h0, 32'h203, 1'b1, 1);
    chk("jalr_bubble0", 32'(ValidD), 32'h0);
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("jalr_addr", last_addr, 32'h202);
    chk("jalr_bubble1", 32'(ValidD), 32'h0);
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("jalr_pcd", PcD, 32'h202);

    // PC wrap-around
    run_cycle(1'b0, 1'b0, 2'b11, 32'hFFFF_FFF8, 32'h0, 1'b1, 1);
    repeat (3) run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("wrap_pcd", PcD, 32'hFFFF_FFFC);
    chk("wrap_pcp4", PcPlus4D, 32'h0);
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("wrap_next_pcd", PcD, 32'h0);

    // reset asserted while a wrong-path request is outstanding
    do_reset();
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 3);
    run_cycle(1'b0, 1'b0, 2'b01, 32'h40, 32'h0, 1'b1, 1);
    do_reset();
    run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);
    chk("post_reset_req", 32'(last_req), 32'h1);
    chk("post_reset_addr", last_addr, RESET_PC);
    repeat (4) run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1);

    // randomized stalls, back-pressure, latency and redirects
    do_reset();
    for (int i = 0; i < 600; i++) begin
      src = ($urandom_range(0, 15) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
      run_cycle($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, src, tgt,
                $urandom(), $urandom_range(0, 3) != 0, $urandom_range(1, 3));
    end
    d0 = deliveries;
    for (int i = 0; i < 60 && deliveries < d0 + 8; i++) begin
      run_cycle(1'b0, 1'b0, 2'b00, 32'h0, 32'h0, $urandom_range(0, 1) == 1, $urandom_range(1, 3));
    end
    chk("random_progress", 32'(deliveries >= d0 + 8), 32'h1);
    chk("random_any_delivery", 32'(deliveries > 40), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch front end of the 5-stage RISC-V pipeline: PC register, instruction-memory request/response sequencing, a one-entry fetch buffer and the IF/ID pipeline register. It is the consumer of the hazard unit's `StallF`, `StallD`, `FlushD` and `PcSrc` outputs and presents `InstrD`/`PcD` to decode. It supports a variable-latency instruction memory with at most one request outstanding, and it discards wrong-path responses after a redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`).

- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `StallF`, `StallD`, `FlushD` in 1 each: from hazard unit.
- `PcSrc` in 2: 00 sequential; 01 `PcTargetE`; 10 `AluResultE & ~1` (jalr); 11 treated as 01.
- `PcTargetE`, `AluResultE` in 32: redirect targets from EX.
- `ImemReqValid` out 1, `ImemReqReady` in 1, `ImemAddr` out 32: request channel.
- `ImemRspValid` in 1, `ImemRspData` in 32: response channel, in order, ≥1 cycle after acceptance.
- `InstrD`, `PcD`, `PcPlus4D` out 32 each; `ValidD` out 1: IF/ID register.

## Operation
- Redirect = `PcSrc != 00`. It has priority over `StallF` and over sequential advance.
- `PcF` register. Next value:
  - Redirect target on redirect.
  - Else `PcF+4` on request handshake (`ImemReqValid && ImemReqReady`).
  - Else hold.
- `ImemAddr = PcF`. The request counts as issued only on handshake, so the address may change while the request is unaccepted.
- Issue condition: `ImemReqValid = !StallF && (state==IDLE || ImemRspValid) && space`.
  - `space` means the buffer is empty at end of cycle, i.e. it is empty now and any response this cycle bypasses, or it drains this cycle.
  - A request issued in a redirect cycle is a wrong-path request.
- FSM tracks the single outstanding request:
  - IDLE: nothing outstanding.
    - Handshake → WAIT, or → DROP if redirect in the same cycle.
  - WAIT: a valid request is outstanding.
    - Rsp without redirect: accept the response; → WAIT if a new request issues, else → IDLE.
    - Redirect (with or without rsp): discard any response this cycle; → DROP if a request is outstanding at end of cycle, else → IDLE.
  - DROP: the outstanding request is wrong-path.
    - Rsp: discard; → WAIT on issue (DROP if redirect again), else → IDLE.
    - No rsp: stay in DROP.
- An `ImemRspValid` in IDLE is ignored.
- Accepted response routing:
  - If the buffer is empty and `!StallD && !FlushD`: bypass directly into IF/ID.
  - Otherwise: write `{ImemRspData, pc}` into the buffer.
- IF/ID update, in priority order:
  1. `FlushD` or redirect: load a bubble and clear the buffer.
  2. `StallD`: hold.
  3. Buffer valid: load from the buffer and clear it.
  4. Bypass response present: load it.
  5. Otherwise: load a bubble.
- Bubble = `InstrD=NOP_INSTR`, `ValidD=0`, PCs zero. A valid load sets `PcPlus4D = pc+4`, mod 2^32.
- Arithmetic is 32-bit; PC wraps 0xFFFF_FFFC → 0x0000_0000.

## Timing
- Reset values:
  - `PcF=RESET_PC`, state IDLE, buffer empty.
  - `InstrD=NOP_INSTR`, `PcD=0`, `PcPlus4D=0`, `ValidD=0`.
  - `ImemReqValid=0` while `reset` is high.
- Reset mid-operation aborts any outstanding request. The memory is reset with the block; stray responses land in IDLE and are ignored.
- Memory with `ImemReqReady=1` and 1-cycle latency:
  - Reset released before edge 0; cycle 0 issues `RESET_PC`.
  - Cycle 1 response bypasses; `InstrD` is valid after edge 1.
  - Steady-state throughput: 1 instruction/cycle.
- Redirect in cycle n with a request in flight:
  - Cycle n+1: response dropped; target issued in the same cycle.
  - Target instruction reaches `InstrD` after edge n+2.
  - `ValidD=0` for two cycles.
- All outputs are registered except `ImemReqValid`, which is combinational from state, `StallF`, `ImemRspValid` and `StallD`/`FlushD`.

## Test plan
- Reset, ready=1, latency 1, memory holds `word[i]=i`:
  - `ImemAddr` 0,4,8,… on consecutive cycles.
  - `InstrD`=0,1,2 on cycles 2,3,4 with `ValidD=1`.
- Latency 3, `ImemReqReady` toggling:
  - Never two outstanding requests; addresses strictly +4.
  - No duplicated or skipped `PcD`.
- `StallD=StallF=1` for 3 cycles with the response landing in the stall window:
  - IF/ID holds; response is buffered and delivered on release.
  - `ImemReqValid=0` throughout the window.
- `PcSrc=01`, `PcTargetE=0x100` while the request for 0x10 is outstanding:
  - 0x10 response discarded; next valid `PcD=0x100`, `PcPlus4D=0x104`.
- `PcSrc=10`, `AluResultE=0x203`: next `ImemAddr=0x202`.
- Reset asserted while in DROP:
  - Outputs return to reset values immediately.
  - First request after release is `RESET_PC`.
